// File: rtl/cic_chan_sched_pkg.sv
// Shared definitions for the CIC channel scheduler: channel-index sizing,
// scheduler state encoding and the flattened-bus slice helper.
package cic_chan_sched_pkg;

  localparam int CIC_MAX_CHANNELS = 16;
  localparam int CH_IDX_WIDTH     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

  // Bit offset of channel n inside a flattened bus of w-bit samples.
  function automatic int slice_off(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/cic_chan_sched_arb.sv
// Combinational round-robin arbiter: rotate by ptr, pick the lowest set bit,
// rotate the winning index back into absolute channel numbering.
module cic_rr_arbiter
  import cic_chan_sched_pkg::*;
#(
  parameter int NUM_CH = CIC_MAX_CHANNELS
) (
  input  logic [NUM_CH-1:0]       elig,
  input  logic [CH_IDX_WIDTH-1:0] ptr,
  output logic [NUM_CH-1:0]       gnt,
  output logic [CH_IDX_WIDTH-1:0] idx,
  output logic                    any
);

  logic [NUM_CH-1:0]       rot;
  logic [CH_IDX_WIDTH-1:0] enc;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rot[i] = elig[(i + int'(ptr)) % NUM_CH];
    end

    // Descending scan so the lowest rotated position (closest to ptr) wins.
    any = 1'b0;
    enc = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        enc = CH_IDX_WIDTH'(i);
      end
    end

    idx = CH_IDX_WIDTH'((int'(enc) + int'(ptr)) % NUM_CH);
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/cic_chan_sched.sv
// Round-robin scheduler serialising per-channel samples into the CIC chain,
// with per-channel decimation phase tracking for the comb sections.
module cic_chan_sched #(
  parameter int MIDDLE_WIDTH          = 37,
  parameter int CIC_MAX_CHANNELS      = 16,
  parameter int CIC_CONFIG_DATA_WIDTH = 16
) (
  input  logic                                     CLK,
  input  logic                                     nRST,
  input  logic                                     Cfg_Load,
  input  logic [CIC_MAX_CHANNELS-1:0]              Chan_Mask,
  input  logic [CIC_CONFIG_DATA_WIDTH-1:0]         Dec_Ratio,
  input  logic [CIC_MAX_CHANNELS-1:0]              Req_Valid,
  input  logic [CIC_MAX_CHANNELS*MIDDLE_WIDTH-1:0] Req_Data,
  output logic [CIC_MAX_CHANNELS-1:0]              Req_Ack,
  input  logic                                     Out_Ready,
  output logic signed [MIDDLE_WIDTH-1:0]           Data_Out,
  output logic                                     Data_Out_Valid,
  output logic [3:0]                               Data_Out_ChIdx,
  output logic                                     Data_Out_Dec
);

  import cic_chan_sched_pkg::*;

  localparam int CW = CIC_CONFIG_DATA_WIDTH;

  logic [CIC_MAX_CHANNELS-1:0]   mask_r;
  logic [CW-1:0]                 ratio_r;
  logic [CH_IDX_WIDTH-1:0]       ptr_r;
  logic [CW-1:0]                 cnt_r [CIC_MAX_CHANNELS];
  sched_state_t                  state_q, state_d;

  logic [CIC_MAX_CHANNELS-1:0]   elig, gnt;
  logic [CH_IDX_WIDTH-1:0]       gnt_idx, ptr_nxt;
  logic                          gnt_any, issue, dec_now;
  logic signed [MIDDLE_WIDTH-1:0] sel_data;

  logic signed [MIDDLE_WIDTH-1:0] data_p1;
  logic [CH_IDX_WIDTH-1:0]        chidx_p1;
  logic                           dec_p1;
  logic [CIC_MAX_CHANNELS-1:0]    ack_p1;
  logic                           vld_p1;

  // A channel acked this cycle still shows its old request; mask it out.
  assign elig = Req_Valid & mask_r & ~ack_p1;

  cic_rr_arbiter #(
    .NUM_CH (CIC_MAX_CHANNELS)
  ) u_arb (
    .elig (elig),
    .ptr  (ptr_r),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  always_comb begin
    sel_data = Req_Data[slice_off(int'(gnt_idx), MIDDLE_WIDTH) +: MIDDLE_WIDTH];
    dec_now  = (cnt_r[gnt_idx] == ratio_r - CW'(1));
    ptr_nxt  = (gnt_idx == CH_IDX_WIDTH'(CIC_MAX_CHANNELS - 1)) ? '0 : gnt_idx + CH_IDX_WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any && !Cfg_Load) begin
          issue   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (Out_Ready) begin
          if (gnt_any && !Cfg_Load) issue   = 1'b1;
          else                      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (Cfg_Load) state_d = IDLE;
  end

  // ---- stage p1: output register, config and per-channel phase ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      mask_r   <= '0;
      ratio_r  <= CW'(1);
      ptr_r    <= '0;
      ack_p1   <= '0;
      data_p1  <= '0;
      chidx_p1 <= '0;
      dec_p1   <= 1'b0;
      for (int i = 0; i < CIC_MAX_CHANNELS; i++) cnt_r[i] <= '0;
    end else begin
      state_q <= state_d;
      ack_p1  <= '0;
      if (Cfg_Load) begin
        mask_r  <= Chan_Mask;
        ratio_r <= (Dec_Ratio == '0) ? CW'(1) : Dec_Ratio;
        ptr_r   <= '0;
        dec_p1  <= 1'b0;
        for (int i = 0; i < CIC_MAX_CHANNELS; i++) cnt_r[i] <= '0;
      end else if (issue) begin
        ack_p1   <= gnt;
        data_p1  <= sel_data;
        chidx_p1 <= gnt_idx;
        dec_p1   <= dec_now;
        cnt_r[gnt_idx] <= dec_now ? '0 : cnt_r[gnt_idx] + CW'(1);
        ptr_r    <= ptr_nxt;
      end
    end
  end

  // The output register holds a sample exactly when the FSM is in HOLD.
  assign vld_p1         = (state_q == HOLD);
  assign Data_Out       = data_p1;
  assign Data_Out_Valid = vld_p1;
  assign Data_Out_ChIdx = chidx_p1;
  assign Data_Out_Dec   = dec_p1;
  assign Req_Ack        = ack_p1;

endmodule

// File: tb/tb_cic_chan_sched.sv
// Self-checking bench for cic_chan_sched: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_cic_chan_sched;

  localparam int N  = 16;
  localparam int W  = 37;
  localparam int CW = 16;
  localparam int VW = 1 + 4 + 1 + W + N;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic            Cfg_Load = 1'b0;
  logic [N-1:0]    Chan_Mask = '0;
  logic [CW-1:0]   Dec_Ratio = '0;
  logic [N-1:0]    Req_Valid = '0;
  logic [N*W-1:0]  Req_Data = '0;
  logic [N-1:0]    Req_Ack;
  logic            Out_Ready = 1'b0;
  logic signed [W-1:0] Data_Out;
  logic            Data_Out_Valid;
  logic [3:0]      Data_Out_ChIdx;
  logic            Data_Out_Dec;

  int passed = 0;
  int total  = 0;
  logic adv_random = 1'b0;

  // Reference model state
  logic [N-1:0] m_mask, m_ack;
  int           m_ratio, m_ptr;
  int           m_cnt [N];
  logic         m_valid, m_dec;
  logic [3:0]   m_idx;
  logic [W-1:0] m_data;

  always #5 CLK = ~CLK;

  cic_chan_sched #(
    .MIDDLE_WIDTH          (W),
    .CIC_MAX_CHANNELS      (N),
    .CIC_CONFIG_DATA_WIDTH (CW)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .Cfg_Load       (Cfg_Load),
    .Chan_Mask      (Chan_Mask),
    .Dec_Ratio      (Dec_Ratio),
    .Req_Valid      (Req_Valid),
    .Req_Data       (Req_Data),
    .Req_Ack        (Req_Ack),
    .Out_Ready      (Out_Ready),
    .Data_Out       (Data_Out),
    .Data_Out_Valid (Data_Out_Valid),
    .Data_Out_ChIdx (Data_Out_ChIdx),
    .Data_Out_Dec   (Data_Out_Dec)
  );

  function automatic logic [W-1:0] rnd_sample();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    m_mask = '0; m_ratio = 1; m_ptr = 0; m_ack = '0;
    m_valid = 1'b0; m_dec = 1'b0; m_idx = '0; m_data = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock edge of the scheduler, described as transactions.
  task automatic model_edge();
    logic [N-1:0] el;
    int k;
    if (Cfg_Load) begin
      m_mask  = Chan_Mask;
      m_ratio = (Dec_Ratio == 0) ? 1 : int'(Dec_Ratio);
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_valid = 1'b0; m_dec = 1'b0; m_ack = '0;
    end else begin
      el = Req_Valid & m_mask & ~m_ack;
      k  = -1;
      for (int i = 0; i < N; i++)
        if (k < 0 && el[(m_ptr + i) % N]) k = (m_ptr + i) % N;
      m_ack = '0;
      if (k >= 0 && (!m_valid || Out_Ready)) begin
        m_data   = Req_Data[k*W +: W];
        m_idx    = 4'(k);
        m_dec    = (m_cnt[k] == m_ratio - 1);
        m_cnt[k] = m_dec ? 0 : m_cnt[k] + 1;
        m_ack[k] = 1'b1;
        m_ptr    = (k + 1) % N;
        m_valid  = 1'b1;
      end else if (m_valid && Out_Ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    for (int n = 0; n < N; n++) begin
      if (m_ack[n]) begin
        Req_Data[n*W +: W] = rnd_sample();
        if (adv_random) Req_Valid[n] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic cfg(input logic [N-1:0] mask, input logic [CW-1:0] ratio);
    Chan_Mask = mask;
    Dec_Ratio = ratio;
    Cfg_Load  = 1'b1;
    step();
    Cfg_Load  = 1'b0;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_idx, m_dec, m_data, m_ack};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {Data_Out_Valid, Data_Out_ChIdx, Data_Out_Dec, Data_Out, Req_Ack};
  endfunction

  task automatic test_reset();
    model_reset();
    Req_Valid = '1;
    for (int n = 0; n < N; n++) Req_Data[n*W +: W] = rnd_sample();
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (obs_vec() !== '0) $display("FAIL reset_state: got %h expected %h", obs_vec(), {VW{1'b0}});
    else passed++;
    @(negedge CLK) nRST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec() || Data_Out_Valid !== 1'b0)
        $display("FAIL reset_mask_zero c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_single_channel();
    int nsamp;
    logic [7:0] decpat;
    nsamp = 0; decpat = '0;
    Req_Valid = 16'h0001;
    Out_Ready = 1'b1;
    cfg(16'h0001, 16'd4);
    for (int c = 0; c < 16; c++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL single_ch c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
      if (Data_Out_Valid) begin
        if (Data_Out_Dec && nsamp < 8) decpat[nsamp] = 1'b1;
        nsamp++;
      end
    end
    total++;
    if (nsamp != 8) $display("FAIL single_ch_count: got %0d expected 8", nsamp);
    else passed++;
    total++;
    if (decpat !== 8'b1000_1000) $display("FAIL single_ch_dec: got %b expected 10001000", decpat);
    else passed++;
  endtask

  task automatic test_back_to_back();
    Req_Valid = '1;
    Out_Ready = 1'b1;
    cfg(16'hFFFF, 16'd2);
    for (int k = 0; k < 34; k++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL b2b_model k%0d: got %h expected %h", k, obs_vec(), exp_vec());
      else passed++;
      total++;
      if (!(Data_Out_Valid === 1'b1 && Data_Out_ChIdx === 4'(k % 16) && Data_Out_Dec === 1'((k / 16) % 2)))
        $display("FAIL b2b_seq k%0d: got v%b idx%0d dec%b expected v1 idx%0d dec%0d",
                 k, Data_Out_Valid, Data_Out_ChIdx, Data_Out_Dec, k % 16, (k / 16) % 2);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] snap;
    Req_Valid = 16'h0005;
    Out_Ready = 1'b0;
    cfg(16'h0005, 16'd1);
    step();
    total++;
    if (obs_vec() !== exp_vec() || Data_Out_ChIdx !== 4'd0)
      $display("FAIL bp_first: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
    snap = {obs_vec()[VW-1:N], {N{1'b0}}};
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (obs_vec() !== snap || obs_vec() !== exp_vec())
        $display("FAIL bp_frozen c%0d: got %h expected %h", c, obs_vec(), snap);
      else passed++;
    end
    Out_Ready = 1'b1;
    step();
    total++;
    if (Data_Out_Valid !== 1'b1 || Data_Out_ChIdx !== 4'd2 || obs_vec() !== exp_vec())
      $display("FAIL bp_release: got v%b idx%0d expected v1 idx2", Data_Out_Valid, Data_Out_ChIdx);
    else passed++;
  endtask

  task automatic test_cfg_flush();
    Req_Valid = 16'h000B;
    Out_Ready = 1'b0;
    cfg(16'h0008, 16'd3);
    repeat (2) step();
    total++;
    if (Data_Out_Valid !== 1'b1 || Data_Out_ChIdx !== 4'd3 || obs_vec() !== exp_vec())
      $display("FAIL flush_hold: got v%b idx%0d expected v1 idx3", Data_Out_Valid, Data_Out_ChIdx);
    else passed++;
    cfg(16'h0003, 16'd2);
    total++;
    if (Data_Out_Valid !== 1'b0 || Req_Ack !== '0 || obs_vec() !== exp_vec())
      $display("FAIL flush_drop: got v%b ack%h expected v0 ack0000", Data_Out_Valid, Req_Ack);
    else passed++;
    Out_Ready = 1'b1;
    step();
    total++;
    if (Data_Out_Valid !== 1'b1 || Data_Out_ChIdx !== 4'd0 || Data_Out_Dec !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL flush_first: got v%b idx%0d dec%b expected v1 idx0 dec0",
               Data_Out_Valid, Data_Out_ChIdx, Data_Out_Dec);
    else passed++;
  endtask

  task automatic test_ratio_zero();
    int acks0, nsamp, bad;
    acks0 = 0; nsamp = 0; bad = 0;
    Req_Valid = 16'h0003;
    Out_Ready = 1'b1;
    cfg(16'h0002, 16'd0);
    for (int c = 0; c < 12; c++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL r0_model c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
      if (Req_Ack[0]) acks0++;
      if (Data_Out_Valid) begin
        nsamp++;
        if (!(Data_Out_Dec && Data_Out_ChIdx == 4'd1)) bad++;
      end
    end
    total++;
    if (acks0 != 0) $display("FAIL r0_ch0_acked: got %0d expected 0", acks0);
    else passed++;
    total++;
    if (bad != 0 || nsamp != 6) $display("FAIL r0_samples: got bad=%0d n=%0d expected bad=0 n=6", bad, nsamp);
    else passed++;
  endtask

  task automatic test_random();
    adv_random = 1'b1;
    for (int r = 0; r < 6; r++) begin
      Req_Valid = N'($urandom());
      cfg(N'($urandom()), CW'($urandom_range(0, 5)));
      for (int c = 0; c < 150; c++) begin
        Out_Ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 40) == 0) begin
          Chan_Mask = N'($urandom());
          Dec_Ratio = CW'($urandom_range(0, 5));
          Cfg_Load  = 1'b1;
        end else begin
          Cfg_Load  = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) Req_Valid = Req_Valid | N'($urandom());
        step();
        total++;
        if (obs_vec() !== exp_vec())
          $display("FAIL random r%0d c%0d: got %h expected %h", r, c, obs_vec(), exp_vec());
        else passed++;
      end
    end
    Cfg_Load   = 1'b0;
    adv_random = 1'b0;
  endtask

  task automatic test_reset_mid();
    Req_Valid = '1;
    Out_Ready = 1'b1;
    cfg(16'hFFFF, 16'd3);
    repeat (5) step();
    total++;
    if (obs_vec() !== exp_vec() || Data_Out_Valid !== 1'b1)
      $display("FAIL rstmid_pre: got %h expected %h", obs_vec(), exp_vec());
    else passed++;
    #2 nRST = 1'b0;
    #1;
    total++;
    if (obs_vec() !== '0) $display("FAIL rstmid_async: got %h expected %h", obs_vec(), {VW{1'b0}});
    else passed++;
    model_reset();
    @(negedge CLK) nRST = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec() || Data_Out_Valid !== 1'b0 || Req_Ack !== '0)
        $display("FAIL rstmid_after c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_back_to_back();
    test_backpressure();
    test_cfg_flush();
    test_ratio_zero();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
